// File: rtl/bit_demux16_pkg.sv
// Shared definitions for the serial-bit-to-word demultiplexer: default width,
// select-width helper and the two-state encoding.
package bit_demux16_pkg;

    localparam int DEF_WIDTH = 16;

    // Select width for a given word width; a 1-bit select is the floor so WIDTH=2 works.
    function automatic int sel_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/bit_demux16_dec.sv
// One-hot decoder turning a bit position into per-bit write enables.
module bit_dec16
    import bit_demux16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = sel_w(WIDTH)
) (
    input  logic [SEL_W-1:0] sel,
    output logic [WIDTH-1:0] onehot
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
            assign onehot[gi] = (sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/bit_demux16.sv
// Assembles single bits from a valid/ready stream into a WIDTH-bit word with a
// written-position mask; publishes on full mask or on commit.
module bit_demux16
    import bit_demux16_pkg::*;
#(
    parameter int   WIDTH    = DEF_WIDTH,
    parameter logic FILL_BIT = 1'b0,
    localparam int  SEL_W    = sel_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_bit,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_addr_en,
    input  logic             in_commit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_word,
    output logic [WIDTH-1:0] out_mask,
    output logic [SEL_W-1:0] ptr
);

    state_t             state_reg;
    logic [WIDTH-1:0]   word_reg;
    logic [WIDTH-1:0]   mask_reg;
    logic [SEL_W-1:0]   ptr_reg;

    logic               accept;
    logic               drain;
    logic [SEL_W-1:0]   pos;
    logic [WIDTH-1:0]   pos_oh;
    logic [WIDTH-1:0]   base_word;
    logic [WIDTH-1:0]   base_mask;
    logic [WIDTH-1:0]   word_next;
    logic [WIDTH-1:0]   mask_next;
    logic               complete;

    assign in_ready  = (state_reg == FILL) || out_ready;
    assign accept    = in_valid && in_ready;
    assign drain     = (state_reg == HOLD) && out_ready;
    assign pos       = in_addr_en ? in_sel : ptr_reg;

    assign out_valid = (state_reg == HOLD);
    assign out_word  = word_reg;
    assign out_mask  = mask_reg;
    assign ptr       = ptr_reg;

    bit_dec16 #(
        .WIDTH (WIDTH),
        .SEL_W (SEL_W)
    ) u_dec (
        .sel    (pos),
        .onehot (pos_oh)
    );

    // A beat accepted while draining lands in the freshly cleared word.
    always_comb begin
        base_word = drain ? {WIDTH{FILL_BIT}} : word_reg;
        base_mask = drain ? '0 : mask_reg;
        word_next = (base_word & ~pos_oh) | (pos_oh & {WIDTH{in_bit}});
        mask_next = base_mask | pos_oh;
        complete  = in_commit || (&mask_next);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= FILL;
            word_reg  <= {WIDTH{FILL_BIT}};
            mask_reg  <= '0;
            ptr_reg   <= '0;
        end else if (accept) begin
            word_reg <= word_next;
            mask_reg <= mask_next;
            if (complete) begin
                state_reg <= HOLD;
                ptr_reg   <= '0;
            end else begin
                state_reg <= FILL;
                ptr_reg   <= pos + 1'b1;
            end
        end else if (drain) begin
            state_reg <= FILL;
            word_reg  <= {WIDTH{FILL_BIT}};
            mask_reg  <= '0;
        end
    end

endmodule

// File: doc/bit_demux16.md
# bit_demux16

Sequential 1-to-16 bit demultiplexer: accepts single bits over a valid/ready stream and steers each into a bit position of a 16-bit word, either by explicit select or by an auto-incrementing pointer. Publishes the assembled word with a per-bit written mask once every position is written, or earlier on commit. It is the write-side counterpart of the 16-input bit multiplexer and is used wherever the datapath rebuilds a word from a serial or per-bit source.

## Interface
- WIDTH, 16, word width; power of two, 2..16; select width SEL_W = log2(WIDTH)
- FILL_BIT, 1'b0, value of unwritten bit positions in out_word

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low; one clock; reset is synchronous and active-low
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat this cycle
- in_bit  in  1  data bit
- in_sel  in  SEL_W  target position when in_addr_en=1
- in_addr_en  in  1  1: write at in_sel; 0: write at internal pointer
- in_commit  in  1  beat closes the word regardless of mask
- out_valid  out  1  assembled word held
- out_ready  in  1  consumer takes word
- out_word  out  WIDTH  assembled word
- out_mask  out  WIDTH  bit i = 1 if position i written
- ptr  out  SEL_W  current auto pointer (status)

## Operation
- States: FILL (assembling), HOLD (word presented).
- Reset (rst_n=0 at edge): state FILL, ptr=0, mask=0, word=all FILL_BIT, out_valid=0; in_ready=1 in the cycle after reset deasserts.
- Accept = in_valid && in_ready. in_ready = (state==FILL) || out_ready.
- Position p = in_addr_en ? in_sel : ptr. On accept: word[p]<=in_bit, mask[p]<=1, ptr<=p+1 mod WIDTH.
- Rewrite of an already-written position: new bit overwrites; mask unchanged; not an error.
- Completion on accept when in_commit=1 or updated mask is all ones: state->HOLD, out_valid=1, ptr<=0.
- HOLD: out_word/out_mask stable until out_ready. On out_valid && out_ready: word cleared to FILL_BIT, mask cleared; state->FILL unless a same-cycle beat completes a new word.
- Simultaneous drain + accept in HOLD: beat written into the freshly cleared word (ptr=0 for auto mode); if it completes (commit, or WIDTH handling n/a beyond single bit), state stays HOLD with the new word next cycle.
- Commit with otherwise empty word: word published with exactly one mask bit set.
- Beats with in_ready=0 are ignored; no side effects.
- Reset mid-word or mid-HOLD: partial word and pending output discarded; no output beat emitted.

## Timing
- Latency: completing beat accepted at edge N -> out_valid=1, word visible after edge N.
- Throughput: one bit per cycle; back-to-back words with zero bubble when out_ready=1 in HOLD.
- out_word, out_mask, out_valid, ptr are registered; in_ready is combinational from state and out_ready only (no path from in_valid).
- out_valid never drops without out_ready handshake except on reset.

## Structure
- Shared package: WIDTH default, SEL_W function (clog2), state encoding constants FILL/HOLD.
- One natural sub-module: bit_dec16 — combinational SEL_W-to-WIDTH one-hot decoder used for word/mask write enables; FSM, pointer and registers in the top.

## Test plan
- Reset, auto mode, 16 beats bits 1,0,1,1,0,0,0,0,1,1,1,1,0,0,0,1 (pos 0..15), out_ready=1 -> one word 0x8F0D, mask 0xFFFF, out_valid one cycle after 16th beat, ptr back to 0.
- Addressed writes sel=3 bit=1, sel=9 bit=1 with commit -> word 0x0208, mask 0x0208; FILL_BIT=1 variant -> word 0xFFFF, mask 0x0208.
- Out_ready held low after completion for 5 cycles with in_valid=1 -> in_ready=0, word stable, no beats consumed; release -> drain then accept continues at pos 0.
- Continuous auto stream, out_ready=1 always -> words every 16 cycles, no dropped bits, in_ready constant 1.
- Rewrite: sel=5 bit=1 then sel=5 bit=0, commit on third beat sel=0 bit=1 -> word 0x0001, mask 0x0021.
- rst_n=0 after 7 auto beats and again during HOLD -> out_valid=0, mask=0, ptr=0; next 16 beats form a correct fresh word.
